pin_route_sequencer: RTL and testbench

PIN_ROUTE_SEQUENCER -- requirements
Module: pin_route_sequencer

---
 rtl/pin_route_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pin_route_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pin_route_sequencer.sv
// Sequences pin-group route changes: tristate guard, apply, settle, one group at a time.
// Optional macro ROUTE_RESET_HOLD_EN: hold_reset follows hiz[3] (otherwise constant 0).
module pin_route_sequencer #(
  parameter int GUARD_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sw_req,
  output logic [3:0] route,
  output logic [3:0] hiz,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_grp,
  output logic       hold_reset
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GUARD  = 2'd1,
    APPLY  = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] rr_q, rr_d;
  logic [1:0] grp_q, grp_d;
  logic       tgt_q, tgt_d;
  logic [3:0] route_q, route_d;
  logic [3:0] hiz_q, hiz_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [1:0] done_grp_q, done_grp_d;

  logic [3:0] pending_s;
  logic [7:0] rot8_s;
  logic [1:0] grant_off_s;
  logic [1:0] grant_idx_s;
  logic       grant_valid_s;

  // Round-robin arbiter: rotate pending so rr_q sits at bit 0, then take the first set bit.
  always_comb begin
    pending_s     = sw_req ^ route_q;
    rot8_s        = {pending_s, pending_s} >> rr_q;
    grant_valid_s = |pending_s;
    casez (rot8_s[3:0])
      4'b???1: grant_off_s = 2'd0;
      4'b??10: grant_off_s = 2'd1;
      4'b?100: grant_off_s = 2'd2;
      4'b1000: grant_off_s = 2'd3;
      default: grant_off_s = 2'd0;
    endcase
    grant_idx_s = rr_q + grant_off_s;
  end

  // State, counter and grant bookkeeping register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rr_q    <= 2'd0;
      grp_q   <= 2'd0;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      grp_q   <= grp_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic; counters load N-1 on entry and stop at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    grp_d   = grp_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          state_d = GUARD;
          cnt_d   = GUARD_LOAD;
          rr_d    = grant_idx_s + 2'd1;
          grp_d   = grant_idx_s;
          tgt_d   = sw_req[grant_idx_s];
        end else begin
          state_d = IDLE;
        end
      end
      GUARD: begin
        if (cnt_q == 8'd0) begin
          state_d = APPLY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      APPLY: begin
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values; hiz/busy look ahead at state_d so they are registered yet cycle-aligned.
  always_comb begin
    route_d = route_q;
    if (state_q == APPLY) begin
      route_d[grp_q] = tgt_q;
    end else begin
      route_d = route_q;
    end
    hiz_d      = (state_d != IDLE) ? (4'b0001 << grp_d) : 4'b0000;
    busy_d     = (state_d != IDLE);
    done_d     = (state_q == SETTLE) && (cnt_q == 8'd0);
    done_grp_d = done_d ? grp_q : done_grp_q;
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      route_q    <= 4'b0000;
      hiz_q      <= 4'b0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_grp_q <= 2'd0;
    end else begin
      route_q    <= route_d;
      hiz_q      <= hiz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_grp_q <= done_grp_d;
    end
  end

  assign route    = route_q;
  assign hiz      = hiz_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_grp = done_grp_q;

`ifdef ROUTE_RESET_HOLD_EN
  logic hold_reset_q;

  // Propeller reset hold tracks the group-3 tristate window.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reset_q <= 1'b0;
    end else begin
      hold_reset_q <= hiz_d[3];
    end
  end

  assign hold_reset = hold_reset_q;
`else
  assign hold_reset = 1'b0;
`endif

endmodule

// File: tb/tb_pin_route_sequencer.sv
// Self-checking bench for pin_route_sequencer: directed scenarios plus random requests,
// checked each cycle against a timeline model of grant cycle T (hiz T+1..T+G+1+S, route at T+G+2, done at T+G+S+2).
module tb_pin_route_sequencer;
  localparam int G = 4;
  localparam int S = 2;

  logic       clock;
  logic       reset;
  logic [3:0] sw_req;
  logic [3:0] route;
  logic [3:0] hiz;
  logic       busy;
  logic       done;
  logic [1:0] done_grp;
  logic       hold_reset;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: one active sequence described by its grant cycle.
  bit         seq_on   = 1'b0;
  int         seq_t    = 0;
  int         seq_g    = 0;
  bit         seq_tgt  = 1'b0;
  bit [3:0]   m_route  = 4'b0000;
  int         m_rr     = 0;
  bit         after_rst = 1'b0;

  pin_route_sequencer #(.GUARD_CYCLES(G), .SETTLE_CYCLES(S)) dut (
    .clock      (clock),
    .reset      (reset),
    .sw_req     (sw_req),
    .route      (route),
    .hiz        (hiz),
    .busy       (busy),
    .done       (done),
    .done_grp   (done_grp),
    .hold_reset (hold_reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  // One clock cycle: check outputs for this cycle, drive inputs, advance the model.
  task automatic step(input logic [3:0] sw, input logic rst);
    int       off;
    logic     e_busy;
    logic     e_done;
    logic     e_hold;
    logic [3:0] e_hiz;
    logic [3:0] pend;
    @(negedge clock);
    off = cyc - seq_t;
    if (seq_on && off == G + 2) m_route[seq_g] = seq_tgt;
    e_busy = seq_on && (off >= 1) && (off <= G + 1 + S);
    e_hiz  = e_busy ? (4'b0001 << seq_g) : 4'b0000;
    e_done = seq_on && (off == G + S + 2);
`ifdef ROUTE_RESET_HOLD_EN
    e_hold = e_hiz[3];
`else
    e_hold = 1'b0;
`endif
    check_eq("route", 32'(route), 32'(m_route));
    check_eq("hiz", 32'(hiz), 32'(e_hiz));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("hold_reset", 32'(hold_reset), 32'(e_hold));
    if (e_done) check_eq("done_grp", 32'(done_grp), 32'(seq_g));
    if (after_rst) check_eq("done_grp_rst", 32'(done_grp), 32'd0);

    sw_req = sw;
    reset  = rst;
    after_rst = rst;
    if (rst) begin
      seq_on  = 1'b0;
      m_route = 4'b0000;
      m_rr    = 0;
    end else if (!seq_on || off >= G + S + 2) begin
      pend = sw ^ m_route;
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_rr + i) % 4;
        if (pend[k]) begin
          seq_on  = 1'b1;
          seq_t   = cyc;
          seq_g   = k;
          seq_tgt = sw[k];
          m_rr    = (k + 1) % 4;
          break;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    logic [3:0] sw;
    logic       rst;
    reset  = 1'b1;
    sw_req = 4'b0000;

    // Reset and long idle.
    repeat (3) step(4'b0000, 1'b1);
    repeat (100) step(4'b0000, 1'b0);
    // Single group 2 request, then return it to 0.
    repeat (12) step(4'b0100, 1'b0);
    repeat (12) step(4'b0000, 1'b0);
    // Groups 0 and 3 together, then both back.
    repeat (20) step(4'b1001, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    // Round robin: finish group 1 (rr -> 2), then 0 and 2 together.
    repeat (10) step(4'b0010, 1'b0);
    repeat (20) step(4'b0111, 1'b0);
    // Revert: bit 1 up for two cycles only.
    repeat (2) step(4'b0000, 1'b1);
    repeat (3) step(4'b0000, 1'b0);
    repeat (2) step(4'b0010, 1'b0);
    repeat (20) step(4'b0000, 1'b0);
    // Abort: reset mid-sequence, request still set afterwards.
    repeat (3) step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    repeat (15) step(4'b0100, 1'b0);

    // Random requests with occasional resets.
    sw = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) sw = 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      step(sw, rst);
    end
    repeat (40) step(sw, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
